trap_controller: RTL and testbench
==================================

Name: trap_controller

Overview:
- Machine-mode trap sequencer sitting between the pipeline MEM stage and the CSR register file.
- Collects exception flags for the instruction in MEM and the external interrupt line, then prioritises them.
- Drives the CSR file's trap-entry strobe and its mepc/mcause/mtval write values, and its mret strobe.
- Redirects the PC to mtvec or mepc and flushes the pipeline while a trap or return is in progress.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on ext_int; legal range 2..4.
- CAUSE_EXT, 32'h8000000B: mcause value for a machine external interrupt.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_valid  in  1  MEM stage holds a real instruction, not a bubble.
- pc_mem  in  32  PC of the MEM instruction.
- inst_mem  in  32  encoding of the MEM instruction.
- addr_mem  in  32  data address of the MEM instruction.
- illegal_inst  in  1  exception flag; cause 2.
- ecall  in  1  exception flag; cause 11.
- l_fault  in  1  load access fault; cause 5.
- s_fault  in  1  store access fault; cause 7.
- mret_in  in  1  MEM instruction is MRET.
- ext_int  in  1  asynchronous external interrupt request, level.
- mstatus  in  32  from the CSR file; bit 3 is MIE.
- mie  in  32  from the CSR file; bit 11 is MEIE.
- mtvec  in  32  from the CSR file.
- mepc  in  32  from the CSR file.
- trap_o  out  1  trap-entry strobe to the CSR file.
- mepc_w  out  32  mepc write value.
- mcause_w  out  32  mcause write value.
- mtval_w  out  32  mtval write value.
- mret_o  out  1  mret strobe to the CSR file.
- redirect  out  1  PC redirect strobe.
- redirect_pc  out  32  redirect target.
- flush  out  1  flush IF/ID/EX/MEM.
- kill_wb  out  1  combinational; block the MEM->WB register write.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; sync chain, int_pending and all registered outputs = 0.
- Interrupt capture:
  - ext_int passes through SYNC_STAGES flops.
  - A synchronised rising edge sets int_pending.
  - int_pending clears only when an interrupt is taken; it stays set while masked.
- Request evaluation, only in IDLE with mem_valid=1. Priority, highest first:
  1. Interrupt: int_pending & mstatus[3] & mie[11]. mcause=CAUSE_EXT, mtval=0.
  2. illegal_inst: mcause=2, mtval=inst_mem.
  3. ecall: mcause=11, mtval=0.
  4. l_fault: mcause=5, mtval=addr_mem.
  5. s_fault: mcause=7, mtval=addr_mem.
  6. mret_in, only if none of the above.
- In every trap case mepc_w=pc_mem. On an interrupt the MEM instruction is not retired; it re-executes after mret.
- kill_wb = (state==IDLE) & mem_valid & (any trap condition). It is combinational in the detect cycle N.
- FSM, states IDLE, TRAP, RET, DRAIN:
  - IDLE -> TRAP on a trap condition at N. Cause, mepc and mtval are registered at the N edge.
  - TRAP (cycle N+1): trap_o=1, redirect=1, redirect_pc={mtvec[31:2],2'b00}, flush=1. Next state DRAIN.
  - IDLE -> RET on mret.
  - RET (N+1): mret_o=1, redirect=1, redirect_pc=mepc, flush=1. Next state DRAIN.
  - DRAIN (N+2): flush=1, redirect=0. Next state IDLE.
- Strobes trap_o, mret_o and redirect are exactly one cycle wide. busy=1 in TRAP, RET and DRAIN.
- Requests arriving outside IDLE are ignored; they are flushed anyway.
- A synchronised edge arriving outside IDLE still sets int_pending.
- Back-to-back: the earliest next trap detection is at N+3, the first cycle back in IDLE.
- Simultaneous events:
  - An interrupt together with any exception takes the interrupt.
  - An exception together with mret takes the exception.
  - An interrupt taken clears int_pending in the same edge as the TRAP entry.
- mepc_w, mcause_w and mtval_w hold their last values when trap_o=0.

Optional Feature:
- Macro TRAP_TIMER_EN.
- When defined:
  - Adds a 32-bit down-counter reloaded with 32'd1000 at reset and at each timer trap entry.
  - On reaching 0 it sets tmr_pending and holds at 0.
  - Timer interrupt condition: tmr_pending & mstatus[3] & mie[7]; mcause=32'h80000007, mtval=0.
  - Priority: below the external interrupt, above all exceptions.
  - tmr_pending clears when the timer trap is taken.
- When not defined: no counter; mie[7] is ignored; behaviour is exactly as above.

Test Plan:
- Reset, then illegal_inst=1, mem_valid=1, pc_mem=0x100, inst_mem=0xFFFFFFFF, mtvec=0x201 -> kill_wb=1 at N. At N+1: trap_o=1, mepc_w=0x100, mcause_w=2, mtval_w=0xFFFFFFFF, redirect_pc=0x200. flush high for 2 cycles; busy low at N+3.
- mstatus=0x88, mie=0x800, pulse ext_int with ecall on the same MEM instruction at pc 0x40 -> mcause_w=0x8000000B, mepc_w=0x40, mtval_w=0, int_pending cleared.
- ext_int pulse with mstatus=0x80 (MIE=0) -> no trap for 20 cycles. Then mstatus=0x88 and mem_valid=1 -> trap taken with CAUSE_EXT.
- mret_in=1, mepc=0x1234 -> mret_o=1 and redirect_pc=0x1234 at N+1. mret_in with l_fault, addr_mem=0x8000 -> mcause_w=5, mtval_w=0x8000, mret_o=0.
- rst_n asserted during TRAP -> all outputs 0 immediately; after release, state IDLE and pending cleared.
- With TRAP_TIMER_EN defined, mie=0x80, mstatus=0x88, mem_valid=1 -> trap at cycle ~1001 with mcause_w=0x80000007.

Source files
------------

// File: rtl/trap_controller.sv
// trap_controller: machine-mode trap sequencer between MEM stage and CSR file; optional timer interrupt via `define TRAP_TIMER_EN
module trap_controller #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] CAUSE_EXT   = 32'h8000000B
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic [31:0] pc_mem,
    input  logic [31:0] inst_mem,
    input  logic [31:0] addr_mem,
    input  logic        illegal_inst,
    input  logic        ecall,
    input  logic        l_fault,
    input  logic        s_fault,
    input  logic        mret_in,
    input  logic        ext_int,
    input  logic [31:0] mstatus,
    input  logic [31:0] mie,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic        trap_o,
    output logic [31:0] mepc_w,
    output logic [31:0] mcause_w,
    output logic [31:0] mtval_w,
    output logic        mret_o,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        kill_wb,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, TRAP, RET, DRAIN} state_t;
    state_t state, nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic        int_q, int_pending, rise, int_take, tmr_take, exc, any_trap, trap_req, ret_req;
    logic [31:0] cause_nxt, tval_nxt;
    assign rise     = sync[SYNC_STAGES-1] & ~int_q;
    assign int_take = int_pending & mstatus[3] & mie[11];
    assign exc      = illegal_inst | ecall | l_fault | s_fault;
    assign any_trap = int_take | tmr_take | exc;
    assign trap_req = (state == IDLE) & mem_valid & any_trap;
    assign ret_req  = (state == IDLE) & mem_valid & mret_in & ~any_trap;
    assign kill_wb  = trap_req;
    assign trap_o   = state == TRAP;
    assign mret_o   = state == RET;
    assign redirect = trap_o | mret_o;
    assign flush    = state != IDLE;
    assign busy     = state != IDLE;
`ifdef TRAP_TIMER_EN
    logic [31:0] tmr_cnt;
    logic        tmr_pending;
    assign tmr_take = tmr_pending & mstatus[3] & mie[7];
    // Free-running down-counter; reloads when its interrupt is actually taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_cnt     <= 32'd1000;
            tmr_pending <= 1'b0;
        end else if (trap_req & tmr_take & ~int_take) begin
            tmr_cnt     <= 32'd1000;
            tmr_pending <= 1'b0;
        end else begin
            tmr_cnt     <= (tmr_cnt == 32'd0) ? 32'd0 : tmr_cnt - 32'd1;
            tmr_pending <= tmr_pending | (tmr_cnt == 32'd0);
        end
    end
    logic unused_bits;
    assign unused_bits = ^{mstatus[31:4], mstatus[2:0], mie[31:12], mie[10:8], mie[6:0], mtvec[1:0]};
`else
    assign tmr_take = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{mstatus[31:4], mstatus[2:0], mie[31:12], mie[10:0], mtvec[1:0]};
`endif
    // Highest-priority source chooses cause and trap value
    always_comb begin
        cause_nxt = int_take ? CAUSE_EXT : tmr_take ? 32'h80000007 : illegal_inst ? 32'd2 :
                    ecall ? 32'd11 : l_fault ? 32'd5 : 32'd7;
        tval_nxt  = (int_take | tmr_take | ecall & ~illegal_inst) ? 32'd0 :
                    illegal_inst ? inst_mem : addr_mem;
    end
    // Next state: a trap or return occupies exactly one strobe cycle plus one drain cycle
    always_comb begin
        nxt = state;
        nxt = (state == IDLE) ? (trap_req ? TRAP : ret_req ? RET : IDLE) :
              (state == DRAIN) ? IDLE : DRAIN;
    end
    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end
    // Synchroniser plus edge latch; a new edge wins over the clear of the interrupt being taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync        <= '0;
            int_q       <= 1'b0;
            int_pending <= 1'b0;
        end else begin
            sync        <= {sync[SYNC_STAGES-2:0], ext_int};
            int_q       <= sync[SYNC_STAGES-1];
            int_pending <= rise | (int_pending & ~(trap_req & int_take));
        end
    end
    // CSR write values and redirect target captured at the detect edge, held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mepc_w      <= '0;
            mcause_w    <= '0;
            mtval_w     <= '0;
            redirect_pc <= '0;
        end else if (trap_req) begin
            mepc_w      <= pc_mem;
            mcause_w    <= cause_nxt;
            mtval_w     <= tval_nxt;
            redirect_pc <= {mtvec[31:2], 2'b00};
        end else if (ret_req) begin
            redirect_pc <= mepc;
        end
    end
endmodule

// File: tb/tb_trap_controller.sv
// tb_trap_controller: directed stimulus with a cycle-level reference model and literal spot checks
module tb_trap_controller;
    localparam int          S     = 2;
    localparam logic [31:0] CAUSE = 32'h8000000B;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        mem_valid = 0, illegal_inst = 0, ecall = 0, l_fault = 0, s_fault = 0, mret_in = 0, ext_int = 0;
    logic [31:0] pc_mem = 0, inst_mem = 0, addr_mem = 0, mstatus = 0, mie = 0, mtvec = 32'h201, mepc = 0;
    logic        trap_o, mret_o, redirect, flush, kill_wb, busy;
    logic [31:0] mepc_w, mcause_w, mtval_w, redirect_pc;
    int checks = 0, failures = 0;
    trap_controller #(.SYNC_STAGES(S), .CAUSE_EXT(CAUSE)) dut (
        .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .pc_mem(pc_mem), .inst_mem(inst_mem),
        .addr_mem(addr_mem), .illegal_inst(illegal_inst), .ecall(ecall), .l_fault(l_fault),
        .s_fault(s_fault), .mret_in(mret_in), .ext_int(ext_int), .mstatus(mstatus), .mie(mie),
        .mtvec(mtvec), .mepc(mepc), .trap_o(trap_o), .mepc_w(mepc_w), .mcause_w(mcause_w),
        .mtval_w(mtval_w), .mret_o(mret_o), .redirect(redirect), .redirect_pc(redirect_pc),
        .flush(flush), .kill_wb(kill_wb), .busy(busy)
    );
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 strobe cycle, 2 drain; hist holds raw ext_int samples
    int          m_phase;
    logic        m_ret, m_pend;
    logic [S:0]  hist;
    logic [31:0] m_mepc, m_cause, m_tval, m_rpc;

    function automatic logic m_int();
        return m_pend & mstatus[3] & mie[11];
    endfunction
    function automatic logic m_any();
        return m_int() | illegal_inst | ecall | l_fault | s_fault;
    endfunction
    function automatic logic [63:0] pick();
        if (m_int())      return {CAUSE, 32'd0};
        if (illegal_inst) return {32'd2, inst_mem};
        if (ecall)        return {32'd11, 32'd0};
        if (l_fault)      return {32'd5, addr_mem};
        return {32'd7, addr_mem};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_ret <= 0; m_pend <= 0; hist <= '0;
            m_mepc <= 0; m_cause <= 0; m_tval <= 0; m_rpc <= 0;
        end else begin
            hist   <= {hist[S-1:0], ext_int};
            m_pend <= (hist[S-1] & ~hist[S]) | (m_pend & ~(m_phase == 0 && mem_valid && m_int()));
            if (m_phase == 0 && mem_valid && m_any()) begin
                m_phase <= 1; m_ret <= 0; m_mepc <= pc_mem;
                {m_cause, m_tval} <= pick();
                m_rpc <= {mtvec[31:2], 2'b00};
            end else if (m_phase == 0 && mem_valid && mret_in) begin
                m_phase <= 1; m_ret <= 1; m_rpc <= mepc;
            end else begin
                m_phase <= (m_phase == 1) ? 2 : 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("trap_o",   32'(trap_o),   32'(m_phase == 1 && !m_ret));
        chk("mret_o",   32'(mret_o),   32'(m_phase == 1 && m_ret));
        chk("redirect", 32'(redirect), 32'(m_phase == 1));
        chk("flush",    32'(flush),    32'(m_phase != 0));
        chk("busy",     32'(busy),     32'(m_phase != 0));
        chk("kill_wb",  32'(kill_wb),  32'(m_phase == 0 && mem_valid && m_any()));
        chk("mepc_w",   mepc_w,   m_mepc);
        chk("mcause_w", mcause_w, m_cause);
        chk("mtval_w",  mtval_w,  m_tval);
        if (m_phase == 1) chk("redirect_pc", redirect_pc, m_rpc);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic clear_in();
        mem_valid = 0; illegal_inst = 0; ecall = 0; l_fault = 0; s_fault = 0; mret_in = 0;
    endtask
    task automatic pulse_int();
        ext_int = 1; step(); ext_int = 0;
        repeat (4) step();
    endtask
    // flags = {illegal, ecall, l_fault, s_fault, mret}
    task automatic exc_case(input string nm, input logic [4:0] f, input logic [31:0] pc, input logic [31:0] inst,
                            input logic [31:0] addr, input logic [31:0] cause, input logic [31:0] tval);
        mem_valid = 1; {illegal_inst, ecall, l_fault, s_fault, mret_in} = f;
        pc_mem = pc; inst_mem = inst; addr_mem = addr;
        @(negedge clk); chk({nm, "_kill"}, 32'(kill_wb), 32'd1);
        step(); clear_in();
        @(negedge clk);
        chk({nm, "_trap"},  32'(trap_o), 32'd1);
        chk({nm, "_mret"},  32'(mret_o), 32'd0);
        chk({nm, "_mepc"},  mepc_w, pc);
        chk({nm, "_cause"}, mcause_w, cause);
        chk({nm, "_tval"},  mtval_w, tval);
        step();
        @(negedge clk); chk({nm, "_drain_flush"}, 32'(flush), 32'd1);
        chk({nm, "_drain_redir"}, 32'(redirect), 32'd0);
        step();
        @(negedge clk); chk({nm, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        repeat (3) step();
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cause", mcause_w, 32'd0);
        step(); rst_n = 1; step();
        exc_case("ill", 5'b10000, 32'h100, 32'hFFFFFFFF, 32'h0, 32'd2, 32'hFFFFFFFF);
        chk("ill_rpc", redirect_pc, 32'h200);
        step();
        exc_case("ecall",  5'b01000, 32'h104, 32'h73, 32'h10, 32'd11, 32'd0);
        step();
        exc_case("lf",     5'b00100, 32'h108, 32'h3, 32'h20, 32'd5, 32'h20);
        step();
        exc_case("sf",     5'b00010, 32'h10C, 32'h23, 32'h30, 32'd7, 32'h30);
        step();
        exc_case("lf_sf",  5'b00110, 32'h110, 32'h3, 32'h44, 32'd5, 32'h44);
        step();
        exc_case("ill_ec", 5'b11000, 32'h114, 32'hDEAD, 32'h0, 32'd2, 32'hDEAD);
        step();
        exc_case("ret_lf", 5'b00101, 32'h118, 32'h0, 32'h8000, 32'd5, 32'h8000);
        step();
        // Back-to-back: a held request retraps at N+3
        mem_valid = 1; illegal_inst = 1; pc_mem = 32'h200; inst_mem = 32'h1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); n += int'(trap_o);
            step();
        end
        clear_in();
        chk("b2b_count", 32'(n), 32'd2);
        repeat (3) step();
        // External interrupt beats a simultaneous ecall
        mstatus = 32'h88; mie = 32'h800;
        pulse_int();
        mem_valid = 1; ecall = 1; pc_mem = 32'h40;
        @(negedge clk); chk("irq_kill", 32'(kill_wb), 32'd1);
        step(); clear_in();
        @(negedge clk);
        chk("irq_cause", mcause_w, 32'h8000000B);
        chk("irq_mepc", mepc_w, 32'h40);
        chk("irq_tval", mtval_w, 32'd0);
        chk("irq_pend_clr", 32'(dut.int_pending), 32'd0);
        repeat (3) step();
        // Masked interrupt stays pending until MIE is set
        mstatus = 32'h80;
        pulse_int();
        mem_valid = 1; pc_mem = 32'h300;
        repeat (20) step();
        @(negedge clk);
        chk("masked_busy", 32'(busy), 32'd0);
        chk("masked_kill", 32'(kill_wb), 32'd0);
        step();
        mstatus = 32'h88;
        @(negedge clk); chk("unmask_kill", 32'(kill_wb), 32'd1);
        step(); clear_in();
        @(negedge clk);
        chk("unmask_cause", mcause_w, CAUSE);
        chk("unmask_mepc", mepc_w, 32'h300);
        repeat (3) step();
        // MRET
        mepc = 32'h1234; mem_valid = 1; mret_in = 1;
        @(negedge clk); chk("mret_kill", 32'(kill_wb), 32'd0);
        step(); clear_in();
        @(negedge clk);
        chk("mret_o", 32'(mret_o), 32'd1);
        chk("mret_trap", 32'(trap_o), 32'd0);
        chk("mret_rpc", redirect_pc, 32'h1234);
        repeat (3) step();
        // Reset in the middle of a trap
        mstatus = 32'h80;
        pulse_int();
        mem_valid = 1; illegal_inst = 1; pc_mem = 32'h500; inst_mem = 32'h77;
        step(); clear_in();
        @(negedge clk); chk("pre_rst_trap", 32'(trap_o), 32'd1);
        #1 rst_n = 0;
        #1;
        chk("rst_trap_o", 32'(trap_o), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_redirect", 32'(redirect), 32'd0);
        chk("rst_mcause", mcause_w, 32'd0);
        chk("rst_mepc", mepc_w, 32'd0);
        repeat (2) step();
        rst_n = 1;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_pend", 32'(dut.int_pending), 32'd0);
        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
